mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
Bus controller placed directly upstream of the unified 8K x 32 instruction/data RAM (1-cycle synchronous read, write-enable port, D_Out held during writes). Converts CPU byte-addressed requests with byte enables into word-level RAM accesses. Performs read-modify-write for partial stores (sb/sh) and returns a one-cycle ready pulse per request. Used by both instruction fetch and load/store through the core's single memory port.

Parameters:
ADDR_W, 13, RAM word-address width (8192 words)
DATA_W, 32, data width; byte enables are DATA_W/8 bits

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req  input  1  CPU request strobe; sampled only in IDLE
we  input  1  1 = store, 0 = load/fetch
addr  input  32  CPU byte address; bits [1:0] ignored for word select
be  input  4  byte enables for stores, be[0] = bits 7:0
wdata  input  32  store data, already lane-aligned
rdata  output  32  registered load data, valid while ready = 1
ready  output  1  one-cycle completion pulse
err  output  1  out-of-range flag, valid with ready (feature-dependent)
mem_W_En  output  1  RAM write enable
mem_Addr  output  13  RAM word address
mem_D_In  output  32  RAM write data
mem_D_Out  input  32  RAM read data, valid the cycle after the address was presented with mem_W_En = 0

Behaviour:
- Reset (async, any state): state = IDLE; rdata = 0; ready = 0; err = 0; mem_W_En = 0; mem_Addr = 0; mem_D_In = 0; latched addr/be/wdata cleared. A request in flight is dropped with no ready.
- States: IDLE, RD, MERGE, WR, ACK.
- IDLE: on req = 1, latch word address addr[14:2], be, wdata, we. Next state:
  - out-of-range (feature enabled): ACK with err = 1;
  - we = 0: RD;
  - we = 1, be = 4'b1111: WR;
  - we = 1, be = 4'b0000: ACK (no RAM access);
  - otherwise: RD (read for RMW).
- RD: mem_Addr = latched address, mem_W_En = 0. Next: MERGE.
- MERGE:
  - load: rdata <= mem_D_Out; next ACK.
  - partial store: merge register <= per byte i, be[i] ? wdata byte i : mem_D_Out byte i; next WR.
- WR: mem_W_En = 1 for exactly this cycle; mem_D_In = wdata (full word) or merged word; mem_Addr = latched address. Next: ACK.
- ACK: ready = 1 for exactly one cycle. rdata is held from the last load; it is unchanged by stores. Next: IDLE. A new req is accepted in IDLE only, so the earliest back-to-back acceptance is the cycle after ACK.
- Latency, req accepted to ready: load 3 cycles; full store 2 cycles; partial store 4 cycles; be = 0 store or error 1 cycle.
- mem_W_En is never asserted outside WR. RAM memory-side outputs are registered or decoded from state only, with no combinational path from req/addr.
- req is ignored outside IDLE. CPU inputs are don't-care after acceptance.
- Word address wraps naturally within 13 bits when the feature is disabled.

Optional Feature:
MEM_BUS_RANGE_CHECK_EN
- Defined: addr[31:15] != 0 is out-of-range. No RAM access occurs; the request goes IDLE -> ACK with err = 1 and rdata unchanged. err = 0 on every other ACK.
- Undefined: upper address bits are ignored (aliasing into the 32 KB RAM). err is tied to 0.

Test Plan:
- Load: preload word 5 = 0xDEADBEEF; req, we = 0, addr = 0x14 -> ready 3 cycles later, rdata = 0xDEADBEEF, mem_W_En never high.
- Full store: we = 1, be = 4'hF, addr = 0x20, wdata = 0x12345678 -> single mem_W_En pulse with mem_Addr = 8; ready after 2 cycles; load of 0x20 returns 0x12345678.
- Partial store: word 8 = 0x12345678; we = 1, be = 4'b0010, wdata = 0x0000AB00 -> written word 0x1234AB78; ready after 4 cycles.
- be = 0 store and req while busy: be = 0 -> ready after 1 cycle, no write. req pulsed during RD/WR -> ignored, exactly one ready per accepted request.
- Reset mid-operation: assert rst during WR -> mem_W_En drops immediately, no ready, all outputs 0. The next load is serviced normally.
- With MEM_BUS_RANGE_CHECK_EN: load addr = 0x00010000 -> ready after 1 cycle, err = 1, no RAM access. Without the macro, the same address reads word 0.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - byte-enable CPU bus to 8K x 32 word RAM bridge with read-modify-write for partial stores.
// Optional out-of-range error reporting is enabled by defining MEM_BUS_RANGE_CHECK_EN.
module mem_bus_ctrl #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                we,
    input  logic [31:0]         addr,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic                err,
    output logic                mem_W_En,
    output logic [ADDR_W-1:0]   mem_Addr,
    output logic [DATA_W-1:0]   mem_D_In,
    input  logic [DATA_W-1:0]   mem_D_Out
);

    typedef enum logic [2:0] {IDLE, RD, MERGE, WR, ACK} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W/8-1:0] be_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   merged;
    logic                we_q;
    logic                oor;
    logic                unused_bits;

`ifdef MEM_BUS_RANGE_CHECK_EN
    logic err_q;
    assign oor         = |addr[31:ADDR_W+2];
    assign unused_bits = ^addr[1:0];
`else
    assign oor         = 1'b0;
    assign unused_bits = ^{addr[31:ADDR_W+2], addr[1:0]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (oor)
                        state_nxt = ACK;
                    else if (!we)
                        state_nxt = RD;
                    else if (&be)
                        state_nxt = WR;
                    else if (be == '0)
                        state_nxt = ACK;
                    else
                        state_nxt = RD;
                end
            end
            RD:      state_nxt = MERGE;
            MERGE:   state_nxt = we_q ? WR : ACK;
            WR:      state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready    = (state == ACK);
        mem_W_En = (state == WR);
        mem_Addr = addr_q;
        mem_D_In = data_q;
        rdata    = rdata_q;
`ifdef MEM_BUS_RANGE_CHECK_EN
        err      = (state == ACK) && err_q;
`else
        err      = 1'b0;
`endif
    end

    // Unselected lanes keep the RAM contents read during RD.
    always_comb begin
        merged = '0;
        for (int i = 0; i < DATA_W/8; i++)
            merged[8*i +: 8] = be_q[i] ? data_q[8*i +: 8] : mem_D_Out[8*i +: 8];
    end

    // data_q doubles as the store-data latch and the merged-word register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            be_q    <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
`ifdef MEM_BUS_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (!oor)
                            addr_q <= addr[ADDR_W+1:2];
                        be_q   <= be;
                        data_q <= wdata;
                        we_q   <= we;
`ifdef MEM_BUS_RANGE_CHECK_EN
                        err_q  <= oor;
`endif
                    end
                end
                MERGE: begin
                    if (we_q)
                        data_q <= merged;
                    else
                        rdata_q <= mem_D_Out;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - scoreboard bench for mem_bus_ctrl with a RAM model and a word-level reference memory.
module tb_mem_bus_ctrl;

`ifdef MEM_BUS_RANGE_CHECK_EN
    localparam bit RANGE = 1'b1;
`else
    localparam bit RANGE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        mem_W_En;
    logic [12:0] mem_Addr;
    logic [31:0] mem_D_In;
    logic [31:0] mem_D_Out;

    mem_bus_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err), .mem_W_En(mem_W_En), .mem_Addr(mem_Addr),
        .mem_D_In(mem_D_In), .mem_D_Out(mem_D_Out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h0100_0193) ^ 32'hA5A5_0F0F;
    endfunction

    logic [31:0] ram [8192];
    bit          ram_wr [8192];

    always @(posedge clk) begin
        if (mem_W_En) begin
            ram[mem_Addr]    <= mem_D_In;
            ram_wr[mem_Addr] <= 1'b1;
        end else begin
            mem_D_Out <= ram_wr[mem_Addr] ? ram[mem_Addr] : init_val(int'(mem_Addr));
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwr;
        logic [12:0] waddr;
        logic [31:0] wval;
        int          issue;
    } exp_t;

    exp_t        q [$];
    logic [31:0] ref_mem [8192];
    bit          ref_wr [8192];
    logic [31:0] last_rd = '0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_W_En) begin
            if (q.size() == 0) begin
                chk("write_without_request", 32'd1, 32'd0);
            end else begin
                chk("write_addr", 32'(mem_Addr), 32'(q[0].waddr));
                chk("write_data", mem_D_In, q[0].wval);
            end
            wr_cnt++;
        end
        if (ready) begin
            if (q.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("latency", 32'(cyc - e.issue), 32'(e.lat));
                chk("err", 32'(err), 32'(e.err));
                chk("rdata", rdata, e.rdata);
                chk("write_count", 32'(wr_cnt), 32'(e.nwr));
            end
            wr_cnt = 0;
        end
    end

    task automatic do_op(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input bit abort);
        exp_t        e;
        int          word;
        logic [31:0] old;
        logic [31:0] mask;
        bit          oor;
        bit          seen;
        word = int'((a >> 2) & 32'h1FFF);
        oor  = RANGE && ((a >> 15) != 0);
        old  = ref_wr[word] ? ref_mem[word] : init_val(word);
        mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        e.err = 1'b0; e.nwr = 0; e.waddr = 13'(word); e.wval = '0;
        if (oor) begin
            e.lat = 1; e.err = 1'b1;
        end else if (!w) begin
            e.lat = 3; last_rd = old;
        end else if (b == 4'hF) begin
            e.lat = 2; e.nwr = 1; e.wval = d;
        end else if (b == 4'h0) begin
            e.lat = 1;
        end else begin
            e.lat = 4; e.nwr = 1; e.wval = (d & mask) | (old & ~mask);
        end
        e.rdata = last_rd;
        e.issue = cyc;
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        q.push_back(e);
        if (abort) begin
            @(negedge clk);
            req = 1'b0;
            #2 rst = 1'b1;
            #1;
            chk("abort_w_en", 32'(mem_W_En), 32'd0);
            chk("abort_ready", 32'(ready), 32'd0);
            chk("abort_err", 32'(err), 32'd0);
            chk("abort_rdata", rdata, 32'd0);
            chk("abort_mem_addr", 32'(mem_Addr), 32'd0);
            chk("abort_mem_d_in", mem_D_In, 32'd0);
            q.delete();
            wr_cnt = 0;
            last_rd = '0;
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ready) begin
                seen = 1'b1;
                req = 1'b0;
                break;
            end
            req = 1'($urandom_range(0, 1)); we = 1'($urandom);
            addr = $urandom; be = 4'($urandom); wdata = $urandom;
        end
        req = 1'b0;
        if (!seen) begin
            chk("ready_timeout", 32'd0, 32'd1);
            q.delete();
            wr_cnt = 0;
        end else if (e.nwr == 1) begin
            ref_mem[word] = e.wval;
            ref_wr[word]  = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  b;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_w_en", 32'(mem_W_En), 32'd0);
        chk("reset_mem_addr", 32'(mem_Addr), 32'd0);
        chk("reset_mem_d_in", mem_D_In, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(1'b1, 32'h14, 4'hF, 32'hDEADBEEF, 1'b0);
        do_op(1'b0, 32'h14, 4'h0, 32'h0, 1'b0);
        do_op(1'b1, 32'h20, 4'hF, 32'h12345678, 1'b0);
        do_op(1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
        do_op(1'b1, 32'h20, 4'b0010, 32'h0000AB00, 1'b0);
        do_op(1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
        do_op(1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 1'b0);
        do_op(1'b0, 32'h23, 4'h0, 32'h0, 1'b0);
        do_op(1'b0, 32'h00010000, 4'h0, 32'h0, 1'b0);
        do_op(1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 1'b1);
        do_op(1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
        do_op(1'b1, 32'h00018004, 4'b1001, 32'h11223344, 1'b0);
        do_op(1'b0, 32'h4, 4'h0, 32'h0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0)
                a = a | ($urandom & 32'hFFFF8000);
            case ($urandom_range(0, 3))
                0:       b = 4'hF;
                1:       b = 4'h0;
                default: b = 4'($urandom);
            endcase
            do_op(1'($urandom), a, b, $urandom, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
